// File: rtl/gear_key_conditioner.sv
// Keypad conditioner for the gear selector: synchronises and debounces
// twelve raw key lines, produces one-clock press pulses on debounced rising
// edges, and runs the P/R/N/D gear selection with a brake and speed
// interlock. Refused gear requests raise a one-clock shift_reject pulse.
module gear_key_conditioner #(
    parameter int DEB_COUNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_sample,
    input  logic [11:0] key_raw,
    input  logic [7:0]  speed,
    output logic [11:0] key_level,
    output logic [11:0] key_press,
    output logic [3:0]  gear,
    output logic        shift_reject
);

    localparam int         NUM_KEYS  = 12;
    localparam logic [3:0] DEB_LIMIT = 4'(DEB_COUNT);

    localparam logic [3:0] GEAR_P = 4'd3;
    localparam logic [3:0] GEAR_R = 4'd6;
    localparam logic [3:0] GEAR_N = 4'd9;
    localparam logic [3:0] GEAR_D = 4'd12;

    // Key bit positions used by the gear logic
    localparam int KEY_3     = 2;
    localparam int KEY_6     = 5;
    localparam int KEY_7     = 6;
    localparam int KEY_9     = 8;
    localparam int KEY_STAR  = 9;
    localparam int KEY_SHARP = 11;

    logic [11:0] r_sync1;
    logic [11:0] r_sync2;
    logic [3:0]  r_cnt [NUM_KEYS];
    logic [11:0] r_key_level;
    logic [11:0] r_key_press;
    logic [3:0]  r_gear;
    logic        r_shift_reject;

    logic [3:0]  w_cnt_next [NUM_KEYS];
    logic [11:0] w_level_next;
    logic [11:0] w_press_next;
    logic [4:0]  w_request;
    logic        w_req_valid;
    logic [3:0]  w_req_gear;
    logic        w_brake;
    logic        w_speed_ok;
    logic        w_gear_legal;
    logic [3:0]  w_gear_next;
    logic        w_reject_next;

    // Priority decode of the press vector into {valid, requested gear}.
    // KEY_3 wins over KEY_6, then KEY_9, then KEY_SHARP.
    function automatic logic [4:0] f_gear_request(input logic [11:0] press);
        logic [4:0] req;
        req = 5'd0;
        if (press[KEY_3]) begin
            req = {1'b1, GEAR_P};
        end else if (press[KEY_6]) begin
            req = {1'b1, GEAR_R};
        end else if (press[KEY_9]) begin
            req = {1'b1, GEAR_N};
        end else if (press[KEY_SHARP]) begin
            req = {1'b1, GEAR_D};
        end else begin
            req = 5'd0;
        end
        return req;
    endfunction

    // Two-flop synchroniser on every raw key line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 12'd0;
            r_sync2 <= 12'd0;
        end else begin
            r_sync1 <= key_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Per-key debounce: count consecutive differing ticks, toggle at the limit
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            w_cnt_next[i]   = r_cnt[i];
            w_level_next[i] = r_key_level[i];
            if (tick_sample) begin
                if (r_sync2[i] != r_key_level[i]) begin
                    if ((r_cnt[i] + 4'd1) == DEB_LIMIT) begin
                        w_level_next[i] = ~r_key_level[i];
                        w_cnt_next[i]   = 4'd0;
                    end else begin
                        w_cnt_next[i]   = r_cnt[i] + 4'd1;
                    end
                end else begin
                    // any agreeing sample restarts qualification
                    w_cnt_next[i] = 4'd0;
                end
            end else begin
                w_cnt_next[i]   = r_cnt[i];
                w_level_next[i] = r_key_level[i];
            end
        end
        w_press_next = w_level_next & ~r_key_level;
    end

    // Debounce state, debounced levels and rising-edge press pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_cnt[i] <= 4'd0;
            end
            r_key_level <= 12'd0;
            r_key_press <= 12'd0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
            r_key_level <= w_level_next;
            r_key_press <= w_press_next;
        end
    end

    // Gear next-state: arbitrate requests and apply the brake/speed interlock
    always_comb begin
        w_request     = f_gear_request(r_key_press);
        w_req_valid   = w_request[4];
        w_req_gear    = w_request[3:0];
        w_brake       = r_key_level[KEY_STAR] | r_key_level[KEY_7];
        w_speed_ok    = ((w_req_gear != GEAR_P) && (w_req_gear != GEAR_R)) ||
                        (speed == 8'd0);
        w_gear_next   = r_gear;
        w_reject_next = 1'b0;

        case (r_gear)
            GEAR_P, GEAR_R, GEAR_N, GEAR_D: w_gear_legal = 1'b1;
            default:                        w_gear_legal = 1'b0;
        endcase

        if (!w_gear_legal) begin
            // a corrupted gear register falls back to Park
            w_gear_next   = GEAR_P;
            w_reject_next = 1'b0;
        end else if (w_req_valid && (w_req_gear != r_gear)) begin
            if (w_brake && w_speed_ok) begin
                w_gear_next   = w_req_gear;
                w_reject_next = 1'b0;
            end else begin
                w_gear_next   = r_gear;
                w_reject_next = 1'b1;
            end
        end else begin
            // no request, or a request for the gear already engaged
            w_gear_next   = r_gear;
            w_reject_next = 1'b0;
        end
    end

    // Gear state register and registered reject pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gear         <= GEAR_P;
            r_shift_reject <= 1'b0;
        end else begin
            r_gear         <= w_gear_next;
            r_shift_reject <= w_reject_next;
        end
    end

    // Outputs are driven straight from registers
    assign key_level    = r_key_level;
    assign key_press    = r_key_press;
    assign gear         = r_gear;
    assign shift_reject = r_shift_reject;

endmodule

// File: tb/tb_gear_key_conditioner.sv
// Self-checking bench for gear_key_conditioner: directed scenarios followed
// by randomized key/speed/tick traffic, all compared every cycle against a
// behavioural model of the keypad and gear selector.
module tb_gear_key_conditioner;

    localparam int DEB = 4;

    localparam logic [11:0] K3    = 12'h004;
    localparam logic [11:0] K6    = 12'h020;
    localparam logic [11:0] K9    = 12'h100;
    localparam logic [11:0] STAR  = 12'h200;
    localparam logic [11:0] SHARP = 12'h800;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_sample = 1'b0;
    logic [11:0] key_raw = 12'd0;
    logic [7:0]  speed = 8'd0;
    logic [11:0] key_level;
    logic [11:0] key_press;
    logic [3:0]  gear;
    logic        shift_reject;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [11:0] m_s1, m_s2, m_level, m_press;
    int          m_run [12];
    logic [3:0]  m_gear;
    logic        m_rej;

    gear_key_conditioner #(.DEB_COUNT(DEB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_sample  (tick_sample),
        .key_raw      (key_raw),
        .speed        (speed),
        .key_level    (key_level),
        .key_press    (key_press),
        .gear         (gear),
        .shift_reject (shift_reject)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 12'd0;
        m_s2 = 12'd0;
        m_level = 12'd0;
        m_press = 12'd0;
        for (int i = 0; i < 12; i++) m_run[i] = 0;
        m_gear = 4'd3;
        m_rej = 1'b0;
    endtask

    // Advance the model by one rising clock edge with the given inputs
    task automatic model_step(input logic [11:0] raw, input logic [7:0] spd, input logic tk);
        int          req_keys [4] = '{2, 5, 8, 11};
        int          req_gear [4] = '{3, 6, 9, 12};
        logic [11:0] old_level;
        logic [11:0] old_press;
        int          target;
        bit          brake;
        old_level = m_level;
        old_press = m_press;
        if (tk) begin
            for (int i = 0; i < 12; i++) begin
                if (m_s2[i] != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_level[i] = ~m_level[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        m_press = m_level & ~old_level;
        target = 0;
        for (int k = 0; k < 4; k++) begin
            if (old_press[req_keys[k]] && target == 0) target = req_gear[k];
        end
        m_rej = 1'b0;
        if (target != 0 && target != int'(m_gear)) begin
            brake = old_level[9] | old_level[6];
            if (brake && (target == 9 || target == 12 || spd == 8'd0))
                m_gear = 4'(target);
            else
                m_rej = 1'b1;
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic step(input logic [11:0] raw, input logic [7:0] spd, input logic tk);
        @(negedge clk);
        key_raw = raw;
        speed = spd;
        tick_sample = tk;
        model_step(raw, spd, tk);
        @(posedge clk);
        #1;
        check_eq("level", key_level, m_level);
        check_eq("press", key_press, m_press);
        check_eq("gear", {8'd0, gear}, {8'd0, m_gear});
        check_eq("reject", {11'd0, shift_reject}, {11'd0, m_rej});
    endtask

    // Hold raw long enough to pass the synchroniser, then give one tick
    task automatic hold_tick(input logic [11:0] raw, input logic [7:0] spd);
        step(raw, spd, 1'b0);
        step(raw, spd, 1'b0);
        step(raw, spd, 1'b0);
        step(raw, spd, 1'b1);
    endtask

    task automatic hold_n(input logic [11:0] raw, input logic [7:0] spd, input int n);
        for (int j = 0; j < n; j++) hold_tick(raw, spd);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_level", key_level, 12'd0);
        check_eq("rst_press", key_press, 12'd0);
        check_eq("rst_gear", {8'd0, gear}, 12'd3);
        check_eq("rst_reject", {11'd0, shift_reject}, 12'd0);
        model_reset();
        @(negedge clk);
        tick_sample = 1'b0;
        rst_n = 1'b1;
        model_step(key_raw, speed, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] cur;
        logic [7:0]  spd;
        model_reset();
        pulse_reset();

        // Bounce on KEY_9: 1,0 then steady 1
        hold_tick(K9, 8'd0);
        hold_tick(12'd0, 8'd0);
        hold_n(K9, 8'd0, 3);
        check_eq("bounce_lvl_early", {11'd0, key_level[8]}, 12'd0);
        hold_tick(K9, 8'd0);
        check_eq("bounce_lvl", {11'd0, key_level[8]}, 12'd1);
        check_eq("bounce_press", {11'd0, key_press[8]}, 12'd1);
        step(K9, 8'd0, 1'b0);
        check_eq("bounce_press_once", {11'd0, key_press[8]}, 12'd0);
        check_eq("no_brake_reject", {11'd0, shift_reject}, 12'd1);
        hold_n(12'd0, 8'd0, 4);

        // Accepted shift P -> D with brake held at standstill
        hold_n(STAR, 8'd0, 4);
        check_eq("brake_lvl", {11'd0, key_level[9]}, 12'd1);
        hold_n(STAR | SHARP, 8'd0, 4);
        check_eq("sharp_press", {11'd0, key_press[11]}, 12'd1);
        check_eq("gear_before", {8'd0, gear}, 12'd3);
        step(STAR | SHARP, 8'd0, 1'b0);
        check_eq("shift_to_d", {8'd0, gear}, 12'd12);
        check_eq("shift_no_reject", {11'd0, shift_reject}, 12'd0);
        hold_n(STAR, 8'd0, 4);

        // Interlock: R while moving, then N without brake
        hold_n(STAR | K6, 8'd40, 4);
        step(STAR | K6, 8'd40, 1'b0);
        check_eq("moving_r_gear", {8'd0, gear}, 12'd12);
        check_eq("moving_r_reject", {11'd0, shift_reject}, 12'd1);
        step(STAR | K6, 8'd40, 1'b0);
        check_eq("reject_one_clk", {11'd0, shift_reject}, 12'd0);
        hold_n(STAR, 8'd40, 4);
        hold_n(12'd0, 8'd40, 4);
        hold_n(K9, 8'd40, 4);
        step(K9, 8'd40, 1'b0);
        check_eq("nobrake_n_gear", {8'd0, gear}, 12'd12);
        check_eq("nobrake_n_reject", {11'd0, shift_reject}, 12'd1);
        hold_n(12'd0, 8'd40, 4);

        // Priority: KEY_6 and KEY_SHARP together
        hold_n(STAR, 8'd0, 4);
        hold_n(STAR | K6 | SHARP, 8'd0, 4);
        check_eq("dual_press", key_press & (K6 | SHARP), K6 | SHARP);
        step(STAR | K6 | SHARP, 8'd0, 1'b0);
        check_eq("priority_gear", {8'd0, gear}, 12'd6);
        check_eq("priority_reject", {11'd0, shift_reject}, 12'd0);
        hold_n(STAR, 8'd0, 4);

        // Same-gear request is ignored
        hold_n(STAR | K9, 8'd0, 4);
        step(STAR | K9, 8'd0, 1'b0);
        check_eq("to_n", {8'd0, gear}, 12'd9);
        hold_n(STAR, 8'd0, 4);
        hold_n(STAR | K9, 8'd0, 4);
        step(STAR | K9, 8'd0, 1'b0);
        check_eq("same_gear", {8'd0, gear}, 12'd9);
        check_eq("same_no_reject", {11'd0, shift_reject}, 12'd0);
        hold_n(12'd0, 8'd0, 4);

        // Reset mid-qualification on KEY_3
        hold_n(K3, 8'd0, 2);
        pulse_reset();
        hold_n(K3, 8'd0, 3);
        check_eq("post_rst_lvl_early", {11'd0, key_level[2]}, 12'd0);
        hold_tick(K3, 8'd0);
        check_eq("post_rst_lvl", {11'd0, key_level[2]}, 12'd1);
        hold_n(12'd0, 8'd0, 4);

        // Randomized traffic with slowly changing keys, brake mostly held
        cur = STAR;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) cur[$urandom_range(11)] ^= 1'b1;
            if ($urandom_range(1) == 0) spd = 8'd0;
            else spd = 8'($urandom_range(255));
            step(cur, spd, 1'($urandom_range(1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
